// File: rtl/interrupt_claim_complete.sv
// Claim/complete controller: latches source requests into pending bits, serves core claims,
// and blocks claimed sources until completed. Define INTERRUPT_EDGE_TRIGGER_EN for edge-triggered gateways.
module interrupt_claim_complete #(
  parameter int N_INTERRUPTS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_INTERRUPTS-1:0] interrupt_requests,
  output logic [N_INTERRUPTS-1:0] pending_interrupts,
  output logic [N_INTERRUPTS-1:0] in_service,
  input  logic [31:0]             active_interrupt_ID,
  input  logic                    claim_req,
  output logic                    claim_valid,
  output logic [31:0]             claim_ID,
  input  logic                    complete_req,
  input  logic [31:0]             complete_ID,
  output logic                    complete_error,
  output logic                    ext_irq
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]              state;
  logic [N_INTERRUPTS-1:0] trigger;
  logic [N_INTERRUPTS-1:0] set_mask;
  logic [N_INTERRUPTS-1:0] claim_mask;
  logic [N_INTERRUPTS-1:0] complete_mask;
  logic                    claim_hit;
  logic                    complete_hit;

`ifdef INTERRUPT_EDGE_TRIGGER_EN
  logic [N_INTERRUPTS-1:0] req_q;

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= interrupt_requests;
  end

  assign trigger = interrupt_requests & ~req_q;
`else
  assign trigger = interrupt_requests;
`endif

  // A source can only be (re)armed while it is neither pending nor in service; in-service
  // is sampled before this edge's completion, so a completed source re-pends one edge later.
  assign set_mask = trigger & ~pending_interrupts & ~in_service;

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int k = 0; k < N_INTERRUPTS; k++) begin
      claim_mask[k]    = claim_req && (active_interrupt_ID == 32'(k + 1));
      complete_mask[k] = complete_req && (complete_ID == 32'(k + 1)) && in_service[k];
    end
  end

  assign claim_hit    = |claim_mask;
  assign complete_hit = |complete_mask;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_interrupts <= '0;
      in_service         <= '0;
      state              <= IDLE;
      claim_valid        <= 1'b0;
      claim_ID           <= '0;
      complete_error     <= 1'b0;
      ext_irq            <= 1'b0;
    end else begin
      pending_interrupts <= (pending_interrupts | set_mask) & ~claim_mask;
      in_service         <= (in_service & ~complete_mask) | claim_mask;
      ext_irq            <= |pending_interrupts;
      complete_error     <= complete_req && !complete_hit;
      claim_valid        <= claim_req;
      if (claim_req) claim_ID <= claim_hit ? active_interrupt_ID : 32'd0;
      case (state)
        IDLE:    state <= claim_req ? RESP : IDLE;
        RESP:    state <= claim_req ? RESP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_claim_complete.sv
// Directed self-checking bench for interrupt_claim_complete; the bench plays the priority resolver.
module tb_interrupt_claim_complete;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] interrupt_requests;
  logic [31:0] pending_interrupts;
  logic [31:0] in_service;
  logic [31:0] active_interrupt_ID;
  logic        claim_req;
  logic        claim_valid;
  logic [31:0] claim_ID;
  logic        complete_req;
  logic [31:0] complete_ID;
  logic        complete_error;
  logic        ext_irq;

  int errors = 0;
  int checks = 0;

  interrupt_claim_complete #(.N_INTERRUPTS(32)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .interrupt_requests  (interrupt_requests),
    .pending_interrupts  (pending_interrupts),
    .in_service          (in_service),
    .active_interrupt_ID (active_interrupt_ID),
    .claim_req           (claim_req),
    .claim_valid         (claim_valid),
    .claim_ID            (claim_ID),
    .complete_req        (complete_req),
    .complete_ID         (complete_ID),
    .complete_error      (complete_error),
    .ext_irq             (ext_irq)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    interrupt_requests  = '0;
    active_interrupt_ID = '0;
    claim_req           = 1'b0;
    complete_req        = 1'b0;
    complete_ID         = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pending_interrupts !== 32'h0) begin errors++; $display("FAIL reset_pending got=%h exp=0", pending_interrupts); end
    checks++; if (in_service !== 32'h0) begin errors++; $display("FAIL reset_in_service got=%h exp=0", in_service); end
    checks++; if (claim_valid !== 1'b0) begin errors++; $display("FAIL reset_claim_valid got=%b exp=0", claim_valid); end
    checks++; if (claim_ID !== 32'h0) begin errors++; $display("FAIL reset_claim_ID got=%0d exp=0", claim_ID); end
    checks++; if (complete_error !== 1'b0) begin errors++; $display("FAIL reset_complete_error got=%b exp=0", complete_error); end
    checks++; if (ext_irq !== 1'b0) begin errors++; $display("FAIL reset_ext_irq got=%b exp=0", ext_irq); end
  endtask

  task automatic test_single_source();
    interrupt_requests = 32'h0000_0010;
    tick();
    checks++; if (pending_interrupts !== 32'h10) begin errors++; $display("FAIL single_pending got=%h exp=10", pending_interrupts); end
    checks++; if (ext_irq !== 1'b0) begin errors++; $display("FAIL single_ext_irq_early got=%b exp=0", ext_irq); end
    tick();
    checks++; if (ext_irq !== 1'b1) begin errors++; $display("FAIL single_ext_irq got=%b exp=1", ext_irq); end
    active_interrupt_ID = 32'd5;
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    active_interrupt_ID = 32'd0;
    checks++; if (claim_valid !== 1'b1) begin errors++; $display("FAIL single_claim_valid got=%b exp=1", claim_valid); end
    checks++; if (claim_ID !== 32'd5) begin errors++; $display("FAIL single_claim_ID got=%0d exp=5", claim_ID); end
    checks++; if (in_service !== 32'h10) begin errors++; $display("FAIL single_in_service got=%h exp=10", in_service); end
    checks++; if (pending_interrupts !== 32'h0) begin errors++; $display("FAIL single_pending_cleared got=%h exp=0", pending_interrupts); end
    tick();
    checks++; if (claim_valid !== 1'b0) begin errors++; $display("FAIL single_claim_valid_drop got=%b exp=0", claim_valid); end
    checks++; if (claim_ID !== 32'd5) begin errors++; $display("FAIL single_claim_ID_hold got=%0d exp=5", claim_ID); end
    checks++; if (pending_interrupts !== 32'h0) begin errors++; $display("FAIL single_no_repend_in_service got=%h exp=0", pending_interrupts); end
  endtask

  // Continues from test_single_source: source 5 in service with its request still high.
  task automatic test_completion_rearm();
    complete_req = 1'b1;
    complete_ID  = 32'd5;
    tick();
    complete_req = 1'b0;
    checks++; if (in_service !== 32'h0) begin errors++; $display("FAIL rearm_in_service got=%h exp=0", in_service); end
    checks++; if (pending_interrupts !== 32'h0) begin errors++; $display("FAIL rearm_same_edge_pending got=%h exp=0", pending_interrupts); end
    checks++; if (complete_error !== 1'b0) begin errors++; $display("FAIL rearm_complete_error got=%b exp=0", complete_error); end
    tick();
`ifdef INTERRUPT_EDGE_TRIGGER_EN
    checks++; if (pending_interrupts !== 32'h0) begin errors++; $display("FAIL rearm_edge_pending got=%h exp=0", pending_interrupts); end
`else
    checks++; if (pending_interrupts !== 32'h10) begin errors++; $display("FAIL rearm_level_pending got=%h exp=10", pending_interrupts); end
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    interrupt_requests = 32'h0000_0044;
    tick();
    interrupt_requests = 32'h0;
    checks++; if (pending_interrupts !== 32'h44) begin errors++; $display("FAIL b2b_pending got=%h exp=44", pending_interrupts); end
    claim_req = 1'b1;
    active_interrupt_ID = 32'd7;
    tick();
    checks++; if (claim_valid !== 1'b1 || claim_ID !== 32'd7) begin errors++; $display("FAIL b2b_first got=%b/%0d exp=1/7", claim_valid, claim_ID); end
    checks++; if (in_service !== 32'h40 || pending_interrupts !== 32'h04) begin errors++; $display("FAIL b2b_first_state got=%h/%h exp=40/04", in_service, pending_interrupts); end
    active_interrupt_ID = 32'd3;
    tick();
    checks++; if (claim_valid !== 1'b1 || claim_ID !== 32'd3) begin errors++; $display("FAIL b2b_second got=%b/%0d exp=1/3", claim_valid, claim_ID); end
    checks++; if (in_service !== 32'h44 || pending_interrupts !== 32'h0) begin errors++; $display("FAIL b2b_second_state got=%h/%h exp=44/0", in_service, pending_interrupts); end
    active_interrupt_ID = 32'd0;
    tick();
    claim_req = 1'b0;
    checks++; if (claim_valid !== 1'b1 || claim_ID !== 32'd0) begin errors++; $display("FAIL b2b_empty got=%b/%0d exp=1/0", claim_valid, claim_ID); end
    checks++; if (in_service !== 32'h44) begin errors++; $display("FAIL b2b_empty_state got=%h exp=44", in_service); end
    tick();
    checks++; if (claim_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b exp=0", claim_valid); end
    checks++; if (ext_irq !== 1'b0) begin errors++; $display("FAIL b2b_ext_irq got=%b exp=0", ext_irq); end
  endtask

  // Continues from test_back_to_back: sources 3 and 7 in service.
  task automatic test_bad_completions();
    logic [31:0] bad_ids [3];
    bad_ids = '{32'd0, 32'd33, 32'd9};
    foreach (bad_ids[i]) begin
      complete_req = 1'b1;
      complete_ID  = bad_ids[i];
      tick();
      checks++; if (complete_error !== 1'b1) begin errors++; $display("FAIL bad_complete_error id=%0d got=%b exp=1", bad_ids[i], complete_error); end
      checks++; if (in_service !== 32'h44 || pending_interrupts !== 32'h0) begin errors++; $display("FAIL bad_complete_state id=%0d got=%h/%h exp=44/0", bad_ids[i], in_service, pending_interrupts); end
    end
    complete_ID = 32'd3;
    tick();
    complete_req = 1'b0;
    checks++; if (complete_error !== 1'b0) begin errors++; $display("FAIL good_complete_error got=%b exp=0", complete_error); end
    checks++; if (in_service !== 32'h40) begin errors++; $display("FAIL good_complete_state got=%h exp=40", in_service); end
    tick();
    checks++; if (complete_error !== 1'b0) begin errors++; $display("FAIL complete_error_pulse got=%b exp=0", complete_error); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    interrupt_requests = 32'h0000_0012;
    tick();
    interrupt_requests = 32'h0;
    claim_req = 1'b1;
    active_interrupt_ID = 32'd5;
    tick();
    checks++; if (in_service !== 32'h10 || pending_interrupts !== 32'h02) begin errors++; $display("FAIL simul_setup got=%h/%h exp=10/02", in_service, pending_interrupts); end
    active_interrupt_ID = 32'd2;
    complete_req = 1'b1;
    complete_ID  = 32'd5;
    tick();
    claim_req = 1'b0;
    complete_req = 1'b0;
    active_interrupt_ID = 32'd0;
    checks++; if (in_service !== 32'h02) begin errors++; $display("FAIL simul_in_service got=%h exp=02", in_service); end
    checks++; if (pending_interrupts !== 32'h0) begin errors++; $display("FAIL simul_pending got=%h exp=0", pending_interrupts); end
    checks++; if (claim_ID !== 32'd2 || complete_error !== 1'b0) begin errors++; $display("FAIL simul_resp got=%0d/%b exp=2/0", claim_ID, complete_error); end
  endtask

  task automatic test_mid_claim_reset();
    do_reset();
    interrupt_requests = 32'h0000_0001;
    tick();
    claim_req = 1'b1;
    active_interrupt_ID = 32'd1;
    tick();
    checks++; if (claim_valid !== 1'b1 || in_service !== 32'h1) begin errors++; $display("FAIL midrst_resp got=%b/%h exp=1/1", claim_valid, in_service); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    claim_req = 1'b0;
    interrupt_requests = 32'h0;
    checks++; if (claim_valid !== 1'b0 || claim_ID !== 32'd0) begin errors++; $display("FAIL midrst_claim got=%b/%0d exp=0/0", claim_valid, claim_ID); end
    checks++; if (pending_interrupts !== 32'h0 || in_service !== 32'h0 || ext_irq !== 1'b0) begin errors++; $display("FAIL midrst_vectors got=%h/%h/%b exp=0/0/0", pending_interrupts, in_service, ext_irq); end
  endtask

  initial begin
    test_reset();
    test_single_source();
    test_completion_rearm();
    test_back_to_back();
    test_bad_completions();
    test_simultaneous();
    test_mid_claim_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
